// File: rtl/st7735_sink_if.sv
// ST7735 4-wire SPI panel link: chip select, serial clock, data, data/command.
// The driver side is the master; the receive-side sink is the slave.
interface st7735_sink_if;
    logic oled_cs;
    logic oled_clk;
    logic oled_mosi;
    logic oled_dc;

    modport master (
        output oled_cs,
        output oled_clk,
        output oled_mosi,
        output oled_dc
    );

    modport slave (
        input oled_cs,
        input oled_clk,
        input oled_mosi,
        input oled_dc
    );
endinterface

// File: rtl/st7735_sink.sv
// ST7735 SPI receive-side sink: oversamples the panel link, assembles bytes,
// decodes CASET/RASET/RAMWR/SWRESET and emits one pixel write per pixel.
module st7735_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 128
) (
    input  logic           clk,
    input  logic           reset,
    st7735_sink_if.slave   bus,
    output logic           cmd_valid,
    output logic [7:0]     cmd_byte,
    output logic           pix_valid,
    output logic [7:0]     pix_x,
    output logic [6:0]     pix_y,
    output logic [15:0]    pix_color,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_SKIP
    } state_t;

    localparam logic [15:0] W_LIM = 16'(WIDTH);
    localparam logic [15:0] H_LIM = 16'(HEIGHT);
    localparam logic [7:0]  X_MAX = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_MAX = 7'(HEIGHT - 1);

    logic [1:0]  cs_q;
    logic [1:0]  sck_q;
    logic [1:0]  sda_q;
    logic [1:0]  dc_q;
    logic        sck_d;
    logic        rise_q;
    logic        sda_r;
    logic        dc_r;
    logic        cs_r;

    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic        dc_cap;
    logic        byte_done;
    logic [7:0]  byte_val;
    logic        byte_dc;

    state_t      state;
    state_t      state_n;
    logic [2:0]  pidx;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        half;
    logic [7:0]  hib;
    logic [7:0]  xs;
    logic [7:0]  xe;
    logic [6:0]  ys;
    logic [6:0]  ye;
    logic [7:0]  ptr_x;
    logic [6:0]  ptr_y;

    logic        cmd_stb;
    logic        dat_stb;
    logic        win_act;
    logic        win_stb;
    logic        win_ok;
    logic        hi_stb;
    logic        pix_stb;
    logic        is_swr;
    logic        is_ramwr;
    logic        x_last;
    logic        y_last;
    logic [15:0] w_start;
    logic [15:0] w_end;
    logic [15:0] w_lim;

    // Two-flop synchronizers; CS idles high so reset cannot fake a byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q  <= 2'b11;
            sck_q <= 2'b00;
            sda_q <= 2'b00;
            dc_q  <= 2'b00;
        end else begin
            cs_q  <= {cs_q[0], bus.oled_cs};
            sck_q <= {sck_q[0], bus.oled_clk};
            sda_q <= {sda_q[0], bus.oled_mosi};
            dc_q  <= {dc_q[0], bus.oled_dc};
        end
    end

    // SCL rising-edge detect, with data and CS aligned to the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_d  <= 1'b0;
            rise_q <= 1'b0;
            sda_r  <= 1'b0;
            dc_r   <= 1'b0;
            cs_r   <= 1'b1;
        end else begin
            sck_d  <= sck_q[1];
            rise_q <= sck_q[1] & ~sck_d & ~cs_q[1];
            sda_r  <= sda_q[1];
            dc_r   <= dc_q[1];
            cs_r   <= cs_q[1];
        end
    end

    // Byte assembly; a CS deassert drops any partial byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            dc_cap    <= 1'b0;
            byte_done <= 1'b0;
            byte_val  <= 8'h00;
            byte_dc   <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_r) begin
                bit_cnt <= 3'd0;
            end else if (rise_q) begin
                shreg   <= {shreg[5:0], sda_r};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd0) begin
                    dc_cap <= dc_r;
                end
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_val  <= {shreg, sda_r};
                    byte_dc   <= dc_cap;
                end
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: every command byte selects the decoder mode.
    always_comb begin
        state_n = state;
        if (byte_done && !byte_dc) begin
            unique case (1'b1)
                byte_val == 8'h2A: state_n = S_CASET;
                byte_val == 8'h2B: state_n = S_RASET;
                byte_val == 8'h2C: state_n = S_RAMWR;
                byte_val == 8'h01: state_n = S_IDLE;
                default:           state_n = S_SKIP;
            endcase
        end
    end

    // Decode strobes for the datapath, derived from state and the new byte.
    always_comb begin
        cmd_stb  = byte_done & ~byte_dc;
        dat_stb  = byte_done & byte_dc;
        win_act  = (state == S_CASET) || (state == S_RASET);
        win_stb  = dat_stb & win_act & (pidx == 3'd3);
        w_start  = {p0, p1};
        w_end    = {p2, byte_val};
        w_lim    = (state == S_CASET) ? W_LIM : H_LIM;
        win_ok   = (p0 == 8'h00) && (p2 == 8'h00) &&
                   (w_start <= w_end) && (w_end < w_lim);
        hi_stb   = dat_stb & (state == S_RAMWR) & ~half;
        pix_stb  = dat_stb & (state == S_RAMWR) & half;
        is_swr   = cmd_stb & (byte_val == 8'h01);
        is_ramwr = cmd_stb & (byte_val == 8'h2C);
        x_last   = ptr_x == xe;
        y_last   = ptr_y == ye;
    end

    // Window, pointer, pixel pairing and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            pix_valid <= 1'b0;
            pix_x     <= 8'd0;
            pix_y     <= 7'd0;
            pix_color <= 16'h0000;
            err       <= 1'b0;
            pidx      <= 3'd0;
            p0        <= 8'h00;
            p1        <= 8'h00;
            p2        <= 8'h00;
            half      <= 1'b0;
            hib       <= 8'h00;
            xs        <= 8'd0;
            xe        <= X_MAX;
            ys        <= 7'd0;
            ye        <= Y_MAX;
            ptr_x     <= 8'd0;
            ptr_y     <= 7'd0;
        end else begin
            cmd_valid <= cmd_stb;
            pix_valid <= pix_stb;
            if (cmd_stb) begin
                cmd_byte <= byte_val;
                pidx     <= 3'd0;
                half     <= 1'b0;
                if (half) begin
                    err <= 1'b1;
                end
            end
            if (is_ramwr) begin
                ptr_x <= xs;
                ptr_y <= ys;
            end
            if (dat_stb && win_act && pidx != 3'd4) begin
                pidx <= pidx + 3'd1;
                case (pidx)
                    3'd0:    p0 <= byte_val;
                    3'd1:    p1 <= byte_val;
                    3'd2:    p2 <= byte_val;
                    default: ;
                endcase
            end
            if (win_stb) begin
                if (!win_ok) begin
                    err <= 1'b1;
                end else if (state == S_CASET) begin
                    xs <= w_start[7:0];
                    xe <= w_end[7:0];
                end else begin
                    ys <= w_start[6:0];
                    ye <= w_end[6:0];
                end
            end
            if (hi_stb) begin
                hib  <= byte_val;
                half <= 1'b1;
            end
            if (pix_stb) begin
                half      <= 1'b0;
                pix_x     <= ptr_x;
                pix_y     <= ptr_y;
                pix_color <= {hib, byte_val};
                if (x_last) begin
                    ptr_x <= xs;
                    ptr_y <= y_last ? ys : ptr_y + 7'd1;
                end else begin
                    ptr_x <= ptr_x + 8'd1;
                end
            end
            if (is_swr) begin
                xs    <= 8'd0;
                xe    <= X_MAX;
                ys    <= 7'd0;
                ye    <= Y_MAX;
                ptr_x <= 8'd0;
                ptr_y <= 7'd0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_st7735_sink.sv
// Self-checking bench for st7735_sink: directed scenarios plus random
// traffic, checked against a transaction-level model of the panel decoder.
module tb_st7735_sink;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [15:0] pix_color;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    logic prev_pix = 1'b0;
    logic prev_cmd = 1'b0;

    pix_t pq[$];
    int   cq[$];

    int  m_xs, m_xe, m_ys, m_ye, m_px, m_py, m_st, m_pidx, m_hib;
    bit  m_half, m_err;
    int  m_prm[4];

    st7735_sink_if bus();

    st7735_sink #(.WIDTH(160), .HEIGHT(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_xs = 0; m_xe = 159; m_ys = 0; m_ye = 127;
        m_px = 0; m_py = 0; m_st = 0; m_pidx = 0;
        m_half = 0; m_err = 0; m_hib = 0;
    endtask

    // Panel behaviour at byte level: 0 idle, 1 caset, 2 raset, 3 ramwr, 4 skip.
    task automatic model_byte(bit dc, int b);
        int s, e, lim;
        if (!dc) begin
            cq.push_back(b);
            if (m_half) m_err = 1;
            m_half = 0;
            m_pidx = 0;
            case (b)
                'h2A: m_st = 1;
                'h2B: m_st = 2;
                'h2C: begin m_st = 3; m_px = m_xs; m_py = m_ys; end
                'h01: begin
                    m_st = 0; m_xs = 0; m_xe = 159; m_ys = 0; m_ye = 127;
                    m_px = 0; m_py = 0; m_err = 0;
                end
                default: m_st = 4;
            endcase
        end else if (m_st == 1 || m_st == 2) begin
            if (m_pidx < 4) begin
                m_prm[m_pidx] = b;
                m_pidx++;
                if (m_pidx == 4) begin
                    s = m_prm[0] * 256 + m_prm[1];
                    e = m_prm[2] * 256 + m_prm[3];
                    lim = (m_st == 1) ? 160 : 128;
                    if (m_prm[0] == 0 && m_prm[2] == 0 && s <= e && e < lim) begin
                        if (m_st == 1) begin m_xs = s; m_xe = e; end
                        else begin m_ys = s; m_ye = e; end
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end else if (m_st == 3) begin
            if (!m_half) begin
                m_hib = b;
                m_half = 1;
            end else begin
                pq.push_back('{x: m_px, y: m_py, c: m_hib * 256 + b});
                m_half = 0;
                if (m_px == m_xe) begin
                    m_px = m_xs;
                    m_py = (m_py == m_ye) ? m_ys : m_py + 1;
                end else begin
                    m_px++;
                end
            end
        end
    endtask

    task automatic send_bits(bit dc, logic [7:0] b, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.oled_cs   = 1'b0;
            bus.oled_dc   = dc;
            bus.oled_mosi = b[7 - i];
            bus.oled_clk  = 1'b0;
            repeat (2) @(negedge clk);
            bus.oled_clk = 1'b1;
            if (i == 7) last_rise = cyc;
            repeat (3) @(negedge clk);
            bus.oled_clk = 1'b0;
        end
    endtask

    task automatic send_byte(bit dc, int b);
        model_byte(dc, b);
        send_bits(dc, 8'(b), 8);
        repeat (4) @(negedge clk);
        chk("err", err, m_err);
    endtask

    task automatic cs_pulse();
        @(negedge clk);
        bus.oled_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic win_cmd(int c, int s, int e);
        send_byte(0, c);
        send_byte(1, s >> 8);
        send_byte(1, s & 255);
        send_byte(1, e >> 8);
        send_byte(1, e & 255);
    endtask

    // Compare every output pulse with the model's expectation queues.
    always @(negedge clk) begin
        if (reset) begin
            if (pix_valid) begin
                pix_t p;
                chk("pix_pending", pq.size() > 0, 1);
                chk("pix_width", prev_pix, 0);
                chk("pix_cmd_both", cmd_valid, 0);
                chk("pix_lat", cyc - last_rise, 5);
                if (pq.size() > 0) begin
                    p = pq.pop_front();
                    chk("pix_x", pix_x, p.x);
                    chk("pix_y", pix_y, p.y);
                    chk("pix_color", pix_color, p.c);
                end
            end
            if (cmd_valid) begin
                chk("cmd_pending", cq.size() > 0, 1);
                chk("cmd_width", prev_cmd, 0);
                chk("cmd_lat", cyc - last_rise, 5);
                if (cq.size() > 0) chk("cmd_byte", cmd_byte, cq.pop_front());
            end
        end
        prev_pix <= pix_valid;
        prev_cmd <= cmd_valid;
    end

    initial begin
        int n, op, s, e;
        bus.oled_cs   = 1'b1;
        bus.oled_clk  = 1'b0;
        bus.oled_mosi = 1'b0;
        bus.oled_dc   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_byte", cmd_byte, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_pix_color", pix_color, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Basic RAMWR
        send_byte(0, 'h2C);
        send_byte(1, 'hF8);
        send_byte(1, 'h00);

        // Windowed write with wrap
        win_cmd('h2A, 2, 3);
        win_cmd('h2B, 5, 6);
        send_byte(0, 'h2C);
        for (int i = 0; i < 5; i++) begin
            send_byte(1, 'h07);
            send_byte(1, 'hE0);
        end

        // Bad CASET after a clean window
        send_byte(0, 'h01);
        win_cmd('h2A, 9, 4);
        win_cmd('h2A, 'h100, 'h110);
        send_byte(0, 'h2C);
        send_byte(1, 'h55);
        send_byte(1, 'hAA);
        send_byte(0, 'h01);

        // CS toggle mid-byte
        send_bits(0, 8'h2C, 5);
        cs_pulse();
        send_bits(0, 8'h2C, 7);
        cs_pulse();
        send_byte(0, 'h2C);
        send_byte(1, 'h12);
        send_byte(1, 'h34);

        // Half pixel then command, then SWRESET
        send_byte(0, 'h2C);
        send_byte(1, 'hAB);
        send_byte(0, 'h00);
        send_byte(0, 'h01);

        // Reset mid-pixel
        send_byte(0, 'h2C);
        send_byte(1, 'h77);
        send_bits(1, 8'h66, 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_cmd_valid", cmd_valid, 0);
        chk("mid_rst_cmd_byte", cmd_byte, 0);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_pix_x", pix_x, 0);
        chk("mid_rst_pix_y", pix_y, 0);
        chk("mid_rst_pix_color", pix_color, 0);
        chk("mid_rst_err", err, 0);
        bus.oled_cs  = 1'b1;
        bus.oled_clk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(0, 'h2C);
        send_byte(1, 'hFF);
        send_byte(1, 'hFF);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    s = $urandom_range(0, 159);
                    e = $urandom_range(s, 159);
                    if ($urandom_range(0, 5) == 0) e = $urandom_range(0, 300);
                    win_cmd('h2A, s, e);
                end
                2, 3: begin
                    s = $urandom_range(0, 127);
                    e = $urandom_range(s, 127);
                    if ($urandom_range(0, 5) == 0) s = $urandom_range(0, 300);
                    win_cmd('h2B, s, e);
                end
                4, 5, 6: begin
                    send_byte(0, 'h2C);
                    n = $urandom_range(1, 13);
                    for (int j = 0; j < n; j++) send_byte(1, $urandom_range(0, 255));
                end
                7: send_byte(0, $urandom_range(0, 255));
                8: send_byte(1, $urandom_range(0, 255));
                default: begin
                    send_bits($urandom_range(0, 1), 8'($urandom), $urandom_range(1, 7));
                    cs_pulse();
                end
            endcase
            if ($urandom_range(0, 3) == 0) cs_pulse();
        end

        repeat (10) @(negedge clk);
        chk("pix_left", pq.size(), 0);
        chk("cmd_left", cq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/st7735_sink.md
# st7735_sink

Receive-side model of the ST7735 4-wire SPI panel link (CS, SCL, SDA, DC): oversamples the serial lines with the system clock, assembles bytes, decodes the CASET/RASET/RAMWR/SWRESET command subset, and emits one pixel write (x, y, RGB565) per completed pixel. It terminates the same signals the `st7735` driver produces. It is used as a loop-back checker in simulation and as an on-FPGA sniffer that feeds a BRAM framebuffer.

## Interface
- WIDTH, 160: panel columns; x range 0..WIDTH-1.
- HEIGHT, 128: panel rows; y range 0..HEIGHT-1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- oled_cs  in  1  chip select, active-low.
- oled_clk  in  1  SPI clock; data sampled on rising edge.
- oled_mosi  in  1  serial data, MSB first.
- oled_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 7.
- cmd_valid  out  1  one-cycle pulse per received command byte.
- cmd_byte  out  8  last command byte; valid with cmd_valid.
- pix_valid  out  1  one-cycle pulse per decoded pixel.
- pix_x  out  8  pixel column.
- pix_y  out  7  pixel row.
- pix_color  out  16  RGB565, first byte = bits 15:8.
- err  out  1  sticky protocol error; cleared by reset or SWRESET.

## Operation
- Inputs pass through a 2-flop synchronizer. A rising edge of the synchronized oled_clk while synchronized oled_cs = 0 shifts in one bit.
- Bit counter 0..7. At count 7, the byte completes and the counter wraps to 0. oled_dc is captured together with the first bit (bit 7).
- Synchronized oled_cs = 1: the bit counter clears and a partial byte is dropped. Command state is retained across CS toggles.
- Decoder states: IDLE, CASET, RASET, RAMWR, SKIP.
  - Any command byte (dc = 0) pulses cmd_valid, resets the parameter index, and selects the next state: 0x2A → CASET, 0x2B → RASET, 0x2C → RAMWR, 0x01 → SWRESET action then IDLE, any other → SKIP.
  - Data bytes in IDLE or SKIP are ignored.
- CASET/RASET take 4 data bytes: start_hi, start_lo, end_hi, end_lo.
  - The window registers update only on the 4th byte, and only if both hi bytes are 0, start ≤ end, and end < WIDTH (CASET) or end < HEIGHT (RASET).
  - Otherwise err is set and the window is unchanged.
  - Any bytes after the 4th are ignored.
- Entering RAMWR loads the pointer with (xs, ys) and clears the half-pixel flag.
  - Data bytes pair up: the first byte goes to the high byte of the color, the second completes the pixel and pulses pix_valid with the current pointer.
  - Pointer advance: x++. At x = xe, x returns to xs and y++. At y = ye as well, y returns to ys (full-window wrap, no error).
- A new command arriving with a half pixel pending discards the half pixel and sets err.
- SWRESET: window returns to (0, WIDTH-1, 0, HEIGHT-1), pointer to (0, 0), err clears, state goes to IDLE.
- Reset values:
  - cmd_valid = 0, cmd_byte = 0x00, pix_valid = 0, pix_x = 0, pix_y = 0, pix_color = 0x0000, err = 0.
  - Window = (0, WIDTH-1, 0, HEIGHT-1); state = IDLE.
- pix_x, pix_y, pix_color, and cmd_byte hold their values between pulses.

## Timing
- Requires oled_clk high and low phases of at least 2 clk cycles each. Performance: byte and pixel throughput are limited only by the SPI rate.
- Latency: pix_valid / cmd_valid rise exactly 4 clk cycles after the first clk edge at which the first synchronizer flop samples the final oled_clk rise of the byte high.
  - Breakdown: 2 synchronizer cycles, 1 edge-detect cycle, 1 decode/register cycle.
- Pulse width: pix_valid and cmd_valid are each exactly one cycle wide, and never both high in the same cycle.
- oled_cs rising mid-byte: the partial byte produces no output, even if 7 bits were received.
- Reset asserted mid-byte or mid-pixel: all outputs take their reset values immediately (asynchronously). Decoding resumes with the first full byte after reset is released and oled_cs is low.

## Test plan
1. **Basic RAMWR.** Reset, then send cmd 0x2C, data 0xF8, 0x00. Expect pix_valid once with x = 0, y = 0, color = 0xF800, 4 cycles after the last SCL rise; err = 0.
2. **Windowed write with wrap.**
   - Stimulus: CASET 00 02 00 03, RASET 00 05 00 06, RAMWR with 5 pixels of 0x07E0.
   - Expected pix_valid coordinates, in order: (2,5), (3,5), (2,6), (3,6), (2,5).
3. **Bad CASET.** Send CASET 00 09 00 04 (start > end), then CASET 01 00 01 10 (hi byte nonzero). Expect err = 1 after each, window unchanged; a subsequent RAMWR pixel lands at (0,0).
4. **CS toggle mid-byte.** Send 5 bits, raise oled_cs, lower it, then send full RAMWR 0x12 0x34. Expect exactly one pix_valid with color = 0x1234 and no cmd_valid for the partial byte.
5. **Half pixel then command.** Send RAMWR, data 0xAB, then cmd 0x00. Expect no pix_valid, err = 1, cmd_valid with cmd_byte = 0x00. Then SWRESET (0x01): expect err = 0.
6. **Reset mid-stream.** Assert reset during byte 2 of a RAMWR pixel. Expect all outputs at reset values while low. After release, a fresh RAMWR 0xFF 0xFF yields a pixel at (0,0) with color 0xFFFF.
